// File: rtl/uart_bridge_pkg.sv
// Shared types and wire-format constants for the UART command bridge.
package uart_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        OPC,
        ADDR,
        DATA,
        CSUM,
        BUS,
        SEND
    } state_t;

    localparam logic [7:0] OP_WR     = 8'h57;
    localparam logic [7:0] OP_RD     = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_BADOP = 8'h3F;
    localparam logic [7:0] RSP_BADCS = 8'h21;

endpackage

// File: rtl/uart_bridge_gap_timer.sv
// Inter-byte gap watchdog: counts enabled cycles since the last accepted byte.
module uart_bridge_gap_timer #(
    parameter int unsigned GAP_CYC = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(GAP_CYC);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear || !enable) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Fires on the GAP_CYC-th consecutive waiting cycle.
    assign expired = enable && (cnt == CNT_W'(GAP_CYC - 1));

endmodule

// File: rtl/uart_bus_bridge.sv
// UART byte-stream to req/ack register bus bridge.
// Optional build macro UART_BRIDGE_CSUM_EN adds XOR checksums to commands and responses.
module uart_bus_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned GAP_CYC    = 100000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx_empty,
    input  logic [7:0]              r_data,
    output logic                    rd_uart,
    input  logic                    tx_full,
    output logic                    wr_uart,
    output logic [7:0]              w_data,
    output logic                    bus_req,
    output logic                    bus_we,
    output logic [ADDR_W-1:0]       bus_addr,
    output logic [8*DATA_BYTES-1:0] bus_wdata,
    input  logic                    bus_ack,
    input  logic [8*DATA_BYTES-1:0] bus_rdata,
    output logic                    busy,
    output logic                    cmd_err
);

    localparam int unsigned CNT_W = $clog2(DATA_BYTES + 2);
    localparam int unsigned IDX_W = $clog2(DATA_BYTES);
`ifdef UART_BRIDGE_CSUM_EN
    localparam int unsigned CSUM_BYTES = 1;
    localparam state_t      AFTER_CMD  = CSUM;
`else
    localparam int unsigned CSUM_BYTES = 0;
    localparam state_t      AFTER_CMD  = BUS;
`endif
    localparam logic REQ_ON_LAST = (AFTER_CMD == BUS);

    state_t                          state;
    logic [CNT_W-1:0]                cnt;
    logic [CNT_W-1:0]                rsp_last;
    logic [7:0]                      rsp_byte;
    logic                            rsp_data;
    logic [DATA_BYTES-1:0][7:0]      wdata_q;
    logic [DATA_BYTES-1:0][7:0]      rdata_q;
    logic                            gap_en;
    logic                            gap_expired;

    assign rd_uart   = (state inside {IDLE, ADDR, DATA, CSUM}) && !rx_empty;
    assign wr_uart   = (state == SEND) && !tx_full;
    assign busy      = (state != IDLE);
    assign bus_wdata = wdata_q;
    assign gap_en    = (state inside {ADDR, DATA, CSUM});

    uart_bridge_gap_timer #(
        .GAP_CYC (GAP_CYC)
    ) u_gap (
        .clk     (clk),
        .reset   (reset),
        .clear   (rd_uart),
        .enable  (gap_en),
        .expired (gap_expired)
    );

`ifdef UART_BRIDGE_CSUM_EN
    logic [7:0] rx_csum;
    logic [7:0] tx_csum;

    // Running XOR of the command seen so far and of the response sent so far.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_csum <= '0;
            tx_csum <= '0;
        end else begin
            if (rd_uart) begin
                rx_csum <= (state == IDLE) ? r_data : (rx_csum ^ r_data);
            end
            if (state != SEND) begin
                tx_csum <= '0;
            end else if (wr_uart) begin
                tx_csum <= tx_csum ^ w_data;
            end
        end
    end
`endif

    always_comb begin
        w_data = rsp_data ? rdata_q[IDX_W'(cnt)] : rsp_byte;
`ifdef UART_BRIDGE_CSUM_EN
        // Only successful responses carry a trailing checksum byte.
        if ((rsp_byte == RSP_OK) && (cnt == rsp_last)) begin
            w_data = tx_csum;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            rsp_last <= '0;
            rsp_byte <= '0;
            rsp_data <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            bus_req  <= 1'b0;
            bus_we   <= 1'b0;
            bus_addr <= '0;
            cmd_err  <= 1'b0;
        end else begin
            cmd_err <= 1'b0;
            case (state)
                IDLE: if (!rx_empty) begin
                    if ((r_data == OP_WR) || (r_data == OP_RD)) begin
                        bus_we <= (r_data == OP_WR);
                        state  <= OPC;
                    end else begin
                        cmd_err  <= 1'b1;
                        rsp_byte <= RSP_BADOP;
                        rsp_data <= 1'b0;
                        rsp_last <= '0;
                        cnt      <= '0;
                        state    <= SEND;
                    end
                end
                OPC: state <= ADDR;
                ADDR: if (!rx_empty) begin
                    bus_addr <= r_data[ADDR_W-1:0];
                    cnt      <= '0;
                    if (bus_we) begin
                        state <= DATA;
                    end else begin
                        state   <= AFTER_CMD;
                        bus_req <= REQ_ON_LAST;
                    end
                end else if (gap_expired) begin
                    cmd_err <= 1'b1;
                    state   <= IDLE;
                end
                DATA: if (!rx_empty) begin
                    wdata_q[IDX_W'(cnt)] <= r_data;
                    if (cnt == CNT_W'(DATA_BYTES - 1)) begin
                        state   <= AFTER_CMD;
                        bus_req <= REQ_ON_LAST;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end else if (gap_expired) begin
                    cmd_err <= 1'b1;
                    state   <= IDLE;
                end
`ifdef UART_BRIDGE_CSUM_EN
                CSUM: if (!rx_empty) begin
                    if (r_data == rx_csum) begin
                        state   <= BUS;
                        bus_req <= 1'b1;
                    end else begin
                        cmd_err  <= 1'b1;
                        rsp_byte <= RSP_BADCS;
                        rsp_data <= 1'b0;
                        rsp_last <= '0;
                        cnt      <= '0;
                        state    <= SEND;
                    end
                end else if (gap_expired) begin
                    cmd_err <= 1'b1;
                    state   <= IDLE;
                end
`endif
                BUS: if (bus_ack) begin
                    bus_req  <= 1'b0;
                    if (!bus_we) begin
                        rdata_q <= bus_rdata;
                    end
                    rsp_data <= !bus_we;
                    rsp_byte <= RSP_OK;
                    rsp_last <= bus_we ? CNT_W'(CSUM_BYTES) : CNT_W'(DATA_BYTES - 1 + CSUM_BYTES);
                    cnt      <= '0;
                    state    <= SEND;
                end
                SEND: if (!tx_full) begin
                    if (cnt == rsp_last) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed self-checking bench for uart_bus_bridge (default build, short gap timeout).
module tb_uart_bus_bridge;

    localparam int unsigned GAP = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_empty = 1'b1;
    logic [7:0]  r_data = 8'h00;
    logic        rd_uart;
    logic        tx_full;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic        bus_req;
    logic        bus_we;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata;
    logic        busy;
    logic        cmd_err;

    uart_bus_bridge #(
        .ADDR_W     (8),
        .DATA_BYTES (4),
        .GAP_CYC    (GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_empty  (rx_empty),
        .r_data    (r_data),
        .rd_uart   (rd_uart),
        .tx_full   (tx_full),
        .wr_uart   (wr_uart),
        .w_data    (w_data),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .busy      (busy),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    int          txcyc[$];
    int          cyc = 0;
    int          last_pop_cyc = 0;
    int          n_err = 0;
    int          n_viol = 0;
    int          n_bus = 0;
    int          ack_delay = 0;
    int          ack_wait = 0;
    logic        bus_hold = 1'b0;
    logic        last_we = 1'b0;
    logic [7:0]  last_addr = 8'h00;
    logic [31:0] last_wdata = 32'h0;
    int          n_cmp = 0;
    int          n_bad = 0;

    // RX FIFO model (first-word-fall-through) plus TX / protocol monitor.
    always @(posedge clk) begin
        if (reset) begin
            rxq.delete();
        end else if (rd_uart) begin
            if (rxq.size() == 0) n_viol++;
            else void'(rxq.pop_front());
            last_pop_cyc = cyc;
        end
        if (wr_uart) begin
            if (tx_full) n_viol++;
            txq.push_back(w_data);
            txcyc.push_back(cyc);
        end
        if (cmd_err) n_err++;
        rx_empty <= (rxq.size() == 0);
        r_data   <= (rxq.size() != 0) ? rxq[0] : 8'h00;
        cyc = cyc + 1;
    end

    // Bus slave: acks after ack_delay waiting cycles unless held off.
    always @(negedge clk) begin
        bus_ack = 1'b0;
        if (bus_req && !bus_hold) begin
            if (ack_wait >= ack_delay) begin
                bus_ack    = 1'b1;
                ack_wait   = 0;
                n_bus++;
                last_we    = bus_we;
                last_addr  = bus_addr;
                last_wdata = bus_wdata;
            end else begin
                ack_wait++;
            end
        end else begin
            ack_wait = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        rxq.push_back(b);
    endtask

    task automatic clear_tx();
        txq.delete();
        txcyc.delete();
    endtask

    task automatic wait_tx(input int n, input int budget, input string tag);
        int i = 0;
        while (txq.size() < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_txcount"}, 32'(txq.size()), 32'(n));
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int e0;
        int b0;
        int i;
        reset     = 1'b1;
        tx_full   = 1'b0;
        bus_rdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_wr_uart", 32'(wr_uart), 32'd0);
        check("rst_cmd_err", 32'(cmd_err), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Write with ack two cycles late.
        clear_tx(); ack_delay = 2; b0 = n_bus;
        push(8'h57); push(8'h10); push(8'hEF); push(8'hBE); push(8'hAD); push(8'hDE);
        wait_tx(1, 200, "wr");
        check("wr_rsp", 32'(txq[0]), 32'h4B);
        check("wr_nbus", 32'(n_bus - b0), 32'd1);
        check("wr_we", 32'(last_we), 32'd1);
        check("wr_addr", 32'(last_addr), 32'h10);
        check("wr_wdata", last_wdata, 32'hDEADBEEF);
        check("wr_idle", 32'(busy), 32'd0);

        // Read.
        clear_tx(); ack_delay = 1; bus_rdata = 32'h12345678;
        push(8'h52); push(8'h20);
        wait_tx(4, 200, "rd");
        check("rd_we", 32'(last_we), 32'd0);
        check("rd_addr", 32'(last_addr), 32'h20);
        check("rd_b0", 32'(txq[0]), 32'h78);
        check("rd_b1", 32'(txq[1]), 32'h56);
        check("rd_b2", 32'(txq[2]), 32'h34);
        check("rd_b3", 32'(txq[3]), 32'h12);

        // Write latency with ack the cycle after bus_req.
        clear_tx(); ack_delay = 1;
        push(8'h57); push(8'h33); push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        wait_tx(1, 200, "lat");
        check("lat_cycles", 32'(txcyc[0] - last_pop_cyc), 32'd3);
        check("lat_wdata", last_wdata, 32'h04030201);
        check("lat_addr", 32'(last_addr), 32'h33);

        // Unknown opcode, then a normal read.
        clear_tx(); e0 = n_err; b0 = n_bus;
        push(8'hAA);
        wait_tx(1, 50, "bad");
        check("bad_rsp", 32'(txq[0]), 32'h3F);
        check("bad_err", 32'(n_err - e0), 32'd1);
        check("bad_nobus", 32'(n_bus - b0), 32'd0);
        clear_tx(); bus_rdata = 32'hCAFEF00D;
        push(8'h52); push(8'h44);
        wait_tx(4, 200, "bad_next");
        check("bad_next_b0", 32'(txq[0]), 32'h0D);
        check("bad_next_b3", 32'(txq[3]), 32'hCA);
        check("bad_next_addr", 32'(last_addr), 32'h44);

        // Gap timeout in DATA.
        clear_tx(); e0 = n_err; b0 = n_bus;
        push(8'h57); push(8'h10);
        repeat (GAP + 20) @(negedge clk);
        check("gap_err", 32'(n_err - e0), 32'd1);
        check("gap_idle", 32'(busy), 32'd0);
        check("gap_nobus", 32'(n_bus - b0), 32'd0);
        check("gap_notx", 32'(txq.size()), 32'd0);

        // TX backpressure during a read response.
        clear_tx(); tx_full = 1'b1; bus_rdata = 32'hA1B2C3D4;
        push(8'h52); push(8'h20);
        repeat (60) @(negedge clk);
        check("bp_notx", 32'(txq.size()), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        tx_full = 1'b0;
        wait_tx(4, 50, "bp");
        check("bp_b0", 32'(txq[0]), 32'hD4);
        check("bp_b1", 32'(txq[1]), 32'hC3);
        check("bp_b2", 32'(txq[2]), 32'hB2);
        check("bp_b3", 32'(txq[3]), 32'hA1);

        // Held bus: RX bytes stay queued; reset drops bus_req at the next edge.
        clear_tx(); bus_hold = 1'b1;
        push(8'h57); push(8'h44); push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        i = 0;
        while (!bus_req && i < 50) begin
            @(negedge clk);
            i++;
        end
        check("hold_req_up", 32'(bus_req), 32'd1);
        push(8'h52);
        repeat (5) @(negedge clk);
        check("hold_rx_kept", 32'(rxq.size()), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_req", 32'(bus_req), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0; bus_hold = 1'b0;
        repeat (3) @(negedge clk);

        check("proto_viol", 32'(n_viol), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
